cnn_mac_pipe: RTL and testbench

// - Parametrised pipelined signed multiply-accumulate for the CNN conv datapaths.
// - Generalises the single-cycle fixed 9x14 signed multiplier:
//   - configurable operand widths and multiply pipeline depth;
//   - clock enable and valid tracking;
//   - per-window accumulation with first/last framing.
// - Sits between the weight/feature line buffers and the conv output requantiser.
//   One instance serves one output channel.

---
 rtl/cnn_mac_pipe.sv | 126 ++++++++++++
 tb/tb_cnn_mac_pipe.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/cnn_mac_pipe.sv
// cnn_mac_pipe: pipelined signed multiply-accumulate for one conv output channel.
//
// The full-precision product din0*din1 runs through NUM_STAGE registers. Each register
// carries {valid, first, last}. A registered accumulator sits after the last product stage.
// It sums each window framed by acc_first/acc_last. On the closing beat it emits the
// window sum on dout with out_valid.
//
// Ports:
//   ap_clk     clock, rising edge
//   ap_rst     synchronous active-high reset, overrides ce
//   ce         clock enable, 0 freezes every register
//   in_valid   qualifies din0/din1/acc_first/acc_last
//   din0       signed feature operand
//   din1       signed weight operand
//   acc_first  beat opens a new accumulation window
//   acc_last   beat closes the window
//   out_valid  dout holds a completed window result
//   dout       signed window sum
//
// Build option: define CNN_MAC_SAT_EN to saturate dout to its signed range instead of
// truncating. The accumulator itself always wraps at ACC_WIDTH.
module cnn_mac_pipe #(
  parameter int ID         = 1,
  parameter int NUM_STAGE  = 3,
  parameter int din0_WIDTH = 9,
  parameter int din1_WIDTH = 14,
  parameter int ACC_WIDTH  = 32,
  parameter int dout_WIDTH = 32
) (
  input  logic                         ap_clk,
  input  logic                         ap_rst,
  input  logic                         ce,
  input  logic                         in_valid,
  input  logic signed [din0_WIDTH-1:0] din0,
  input  logic signed [din1_WIDTH-1:0] din1,
  input  logic                         acc_first,
  input  logic                         acc_last,
  output logic                         out_valid,
  output logic signed [dout_WIDTH-1:0] dout
);

  localparam int P = din0_WIDTH + din1_WIDTH;

  // ID is a tag only
  logic unused_id;
  assign unused_id = ^32'(ID);

  logic signed [P-1:0]          prod_in;
  logic signed [P-1:0]          prod_q [NUM_STAGE];
  logic [NUM_STAGE-1:0]         valid_q;
  logic [NUM_STAGE-1:0]         first_q;
  logic [NUM_STAGE-1:0]         last_q;
  logic signed [ACC_WIDTH-1:0]  acc_q;
  logic signed [ACC_WIDTH-1:0]  acc_d;
  logic signed [ACC_WIDTH-1:0]  prod_ext;
  logic signed [dout_WIDTH-1:0] fmt_val;

  assign prod_in  = din0 * din1;
  assign prod_ext = ACC_WIDTH'(prod_q[NUM_STAGE-1]);

  always_comb begin
    acc_d = acc_q;
    if (first_q[NUM_STAGE-1]) begin
      acc_d = prod_ext;
    end else begin
      acc_d = acc_q + prod_ext;
    end
  end

  if (dout_WIDTH == ACC_WIDTH) begin : g_full
    assign fmt_val = acc_d;
  end else begin : g_narrow
`ifdef CNN_MAC_SAT_EN
    // Sum fits when every bit from the dout sign bit upward agrees
    logic [ACC_WIDTH-dout_WIDTH:0] hi;
    assign hi = acc_d[ACC_WIDTH-1:dout_WIDTH-1];
    always_comb begin
      if ((&hi) || !(|hi)) begin
        fmt_val = acc_d[dout_WIDTH-1:0];
      end else if (hi[ACC_WIDTH-dout_WIDTH]) begin
        fmt_val = {1'b1, {(dout_WIDTH-1){1'b0}}};
      end else begin
        fmt_val = {1'b0, {(dout_WIDTH-1){1'b1}}};
      end
    end
`else
    assign fmt_val = acc_d[dout_WIDTH-1:0];
`endif
  end

  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      valid_q   <= '0;
      first_q   <= '0;
      last_q    <= '0;
      for (int i = 0; i < NUM_STAGE; i++) begin
        prod_q[i] <= '0;
      end
      acc_q     <= '0;
      out_valid <= 1'b0;
      dout      <= '0;
    end else if (ce) begin
      // Flags are masked by in_valid so bubbles can never open or close a window
      valid_q[0] <= in_valid;
      first_q[0] <= in_valid & acc_first;
      last_q[0]  <= in_valid & acc_last;
      prod_q[0]  <= prod_in;
      for (int i = 1; i < NUM_STAGE; i++) begin
        valid_q[i] <= valid_q[i-1];
        first_q[i] <= first_q[i-1];
        last_q[i]  <= last_q[i-1];
        prod_q[i]  <= prod_q[i-1];
      end
      if (valid_q[NUM_STAGE-1]) begin
        acc_q <= acc_d;
      end
      if (valid_q[NUM_STAGE-1] && last_q[NUM_STAGE-1]) begin
        out_valid <= 1'b1;
        dout      <= fmt_val;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cnn_mac_pipe.sv
// Bench for cnn_mac_pipe: a 32-bit-output instance and a 16-bit-output instance share
// stimulus. Both are checked every cycle against a window-sum model.
module tb_cnn_mac_pipe;

  logic               ap_clk = 1'b0;
  logic               ap_rst;
  logic               ce;
  logic               in_valid;
  logic signed [8:0]  din0;
  logic signed [13:0] din1;
  logic               acc_first;
  logic               acc_last;
  logic               out_valid;
  logic signed [31:0] dout;
  logic               out_valid16;
  logic signed [15:0] dout16;

  always #5 ap_clk = ~ap_clk;

  cnn_mac_pipe #(
    .ID(1), .NUM_STAGE(3), .din0_WIDTH(9), .din1_WIDTH(14), .ACC_WIDTH(32), .dout_WIDTH(32)
  ) u_dut (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .in_valid(in_valid), .din0(din0),
    .din1(din1), .acc_first(acc_first), .acc_last(acc_last), .out_valid(out_valid),
    .dout(dout)
  );

  cnn_mac_pipe #(
    .ID(2), .NUM_STAGE(3), .din0_WIDTH(9), .din1_WIDTH(14), .ACC_WIDTH(32), .dout_WIDTH(16)
  ) u_dut16 (
    .ap_clk(ap_clk), .ap_rst(ap_rst), .ce(ce), .in_valid(in_valid), .din0(din0),
    .din1(din1), .acc_first(acc_first), .acc_last(acc_last), .out_valid(out_valid16),
    .dout(dout16)
  );

  typedef struct {
    int unsigned        due;
    logic signed [31:0] v32;
    logic signed [15:0] v16;
  } res_t;

  res_t               pend[$];
  int                 n_cmp = 0;
  int                 n_bad = 0;
  int unsigned        en_n = 0;
  int                 sum = 0;
  logic               exp_ov = 1'b0;
  logic signed [31:0] exp_dout = '0;
  logic signed [15:0] exp_dout16 = '0;
  int                 ov_cnt = 0;
  logic signed [31:0] last_dout = '0;
  logic signed [15:0] last_dout16 = '0;
  int                 lat;

  task automatic check(input string tag, input logic signed [63:0] got,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic signed [15:0] fmt16(input int a);
    logic [31:0] t;
`ifdef CNN_MAC_SAT_EN
    if (a > 32767) return 16'h7fff;
    if (a < -32768) return 16'h8000;
`endif
    t = a;
    return t[15:0];
  endfunction

  // One clock: drive on the falling edge, update the model at the rising edge, check 1 time unit later
  task automatic step(input bit rst, input bit c, input bit v, input int a, input int b,
                      input bit f, input bit l);
    int p;
    @(negedge ap_clk);
    ap_rst = rst; ce = c; in_valid = v; din0 = 9'(a); din1 = 14'(b);
    acc_first = f; acc_last = l;
    @(posedge ap_clk);
    if (rst) begin
      pend.delete();
      sum = 0; exp_ov = 1'b0; exp_dout = '0; exp_dout16 = '0;
    end else if (c) begin
      en_n++;
      if (v) begin
        p = int'(din0) * int'(din1);
        sum = f ? p : sum + p;
        if (l) pend.push_back('{en_n + 3, sum, fmt16(sum)});
      end
      if (pend.size() > 0 && pend[0].due == en_n) begin
        exp_ov = 1'b1; exp_dout = pend[0].v32; exp_dout16 = pend[0].v16;
        void'(pend.pop_front());
      end else begin
        exp_ov = 1'b0;
      end
    end
    #1;
    check("out_valid", out_valid, exp_ov);
    check("dout", dout, exp_dout);
    check("out_valid16", out_valid16, exp_ov);
    check("dout16", dout16, exp_dout16);
    if (out_valid && c && !rst) begin
      ov_cnt++; last_dout = dout; last_dout16 = dout16;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 1, 0, 0, 0, 0, 0);
  endtask

  initial begin
    ap_rst = 1'b1; ce = 1'b0; in_valid = 1'b0; din0 = '0; din1 = '0;
    acc_first = 1'b0; acc_last = 1'b0;
    step(1, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0);

    // Single first&last beat: latency counted from the accepting cycle
    ov_cnt = 0; lat = 0;
    step(0, 1, 1, -256, -8192, 1, 1);
    for (int i = 1; i <= 8; i++) begin
      step(0, 1, 0, 0, 0, 0, 0);
      if (out_valid && lat == 0) lat = i + 1;
    end
    check("beat_latency", lat, 4);
    check("beat_dout", last_dout, 2097152);
    check("beat_count", ov_cnt, 1);

    // Three-beat window
    ov_cnt = 0;
    step(0, 1, 1, 3, 5, 1, 0);
    step(0, 1, 1, -7, 2, 0, 0);
    step(0, 1, 1, 100, -1, 0, 1);
    idle(6);
    check("win_count", ov_cnt, 1);
    check("win_dout", last_dout, -99);

    // Same window with ce low for two cycles mid-pipeline and once while out_valid is up
    ov_cnt = 0; lat = 0;
    step(0, 1, 1, 3, 5, 1, 0);
    step(0, 1, 1, -7, 2, 0, 0);
    step(0, 1, 1, 100, -1, 0, 1);
    for (int i = 1; i <= 8; i++) begin
      step(0, (i == 2 || i == 3 || i == 6) ? 1'b0 : 1'b1, 0, 0, 0, 0, 0);
      if (out_valid && lat == 0) lat = i + 1;
      if (i == 6) check("ce_hold_valid", out_valid, 1);
    end
    check("ce_latency", lat, 6);
    check("ce_dout", last_dout, -99);
    check("ce_count", ov_cnt, 1);

    // Bubbles carrying stray flags, then back-to-back windows
    ov_cnt = 0;
    step(0, 1, 1, 10, 10, 1, 0);
    step(0, 1, 0, 77, 77, 1, 1);
    step(0, 1, 1, 20, -3, 0, 1);
    step(0, 1, 1, -5, 7, 1, 0);
    step(0, 1, 0, 9, 9, 0, 1);
    step(0, 1, 1, 1, 1, 0, 1);
    idle(6);
    check("b2b_count", ov_cnt, 2);
    check("b2b_dout2", last_dout, -34);

    // 16-bit output: 2*100*200 = 40000 overflows the signed 16-bit range
    step(0, 1, 1, 100, 200, 1, 0);
    step(0, 1, 1, 100, 200, 0, 1);
    idle(6);
    check("dout32_40000", last_dout, 40000);
`ifdef CNN_MAC_SAT_EN
    check("dout16_sat", last_dout16, 32767);
`else
    check("dout16_wrap", last_dout16, -25536);
`endif

    // Reset with two beats in flight, then a window without first sums from zero
    ov_cnt = 0;
    step(0, 1, 1, 50, 50, 1, 0);
    step(0, 1, 1, 50, 50, 0, 1);
    step(1, 1, 0, 0, 0, 0, 0);
    idle(6);
    check("rst_count", ov_cnt, 0);
    check("rst_dout", dout, 0);
    step(0, 1, 1, 2, 3, 0, 1);
    idle(5);
    check("rst_next_dout", last_dout, 6);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step(($urandom_range(0, 199) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) < 7) ? 1'b1 : 1'b0,
           $signed($urandom_range(0, 511)) - 256,
           $signed($urandom_range(0, 16383)) - 8192,
           ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0,
           ($urandom_range(0, 9) < 3) ? 1'b1 : 1'b0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
